// File: rtl/chacha20_stream_ctrl.sv
// chacha20_stream_ctrl
// ---------------------------------------------------------------------------
// Sequencer between a stream fabric and a chacha20 keystream core. It latches
// key/nonce/initial block counter, requests one 512-bit keystream block at a
// time, and XORs the 16 32-bit words of each block, in order (word 0 = low
// bits), onto plaintext beats to form a 32-bit AXI-Stream cipher path.
//
// Parameters
//   CORE_TIMEOUT : cycles to wait for keystream after start (0 = no timeout)
//   TW           : timeout counter width, 2^TW > CORE_TIMEOUT
//
// Ports
//   i_aclk, i_aresetn         : clock, asynchronous active-low reset
//   i_cfg_*                   : cfg pulse + key/nonce/counter (taken in IDLE)
//   o_core_*                  : enable/start/key/nonce/counter to the core
//   i_core_keystream(_valid)  : 512-bit block returned by the core
//   s_axis_*                  : plaintext in
//   m_axis_*                  : ciphertext out (combinational XOR)
//   o_busy                    : FSM not in IDLE
//   o_error                   : sticky timeout / counter exhaustion flag
//
// Build option
//   CHACHA20_CTRL_PREFETCH_EN : adds a spare block buffer; the next block is
//   requested as soon as the current one starts streaming so block changes
//   happen without bubbles when the spare is already filled.
// ---------------------------------------------------------------------------
module chacha20_stream_ctrl #(
   parameter int CORE_TIMEOUT = 256,
   parameter int TW           = 9
) (
   input  logic           i_aclk,
   input  logic           i_aresetn,
   input  logic           i_cfg_valid,
   input  logic [255:0]   i_cfg_key,
   input  logic [95:0]    i_cfg_nonce,
   input  logic [31:0]    i_cfg_counter,
   output logic           o_core_enable,
   output logic           o_core_start,
   output logic [255:0]   o_core_key,
   output logic [95:0]    o_core_nonce,
   output logic [31:0]    o_core_counter,
   input  logic [511:0]   i_core_keystream,
   input  logic           i_core_keystream_valid,
   input  logic [31:0]    s_axis_tdata,
   input  logic           s_axis_tvalid,
   input  logic           s_axis_tlast,
   output logic           s_axis_tready,
   output logic [31:0]    m_axis_tdata,
   output logic           m_axis_tvalid,
   output logic           m_axis_tlast,
   input  logic           m_axis_tready,
   output logic           o_busy,
   output logic           o_error
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REQ    = 2'd1,
      S_WAIT   = 2'd2,
      S_STREAM = 2'd3
   } state_t;

   localparam logic [TW-1:0] TMO_LAST = TW'((CORE_TIMEOUT > 0) ? CORE_TIMEOUT - 1 : 0);
   localparam logic [31:0]   CTR_MAX  = 32'hFFFF_FFFF;

   state_t         state_q, state_d;
   logic [255:0]   key_q, key_d;
   logic [95:0]    nonce_q, nonce_d;
   logic [31:0]    ctr_q, ctr_d;
   logic [511:0]   blk_q, blk_d;
   logic [3:0]     idx_q, idx_d;
   logic [TW-1:0]  tmr_q, tmr_d;
   logic           cfg_seen_q, cfg_seen_d;
   logic           err_q, err_d;

`ifdef CHACHA20_CTRL_PREFETCH_EN
   logic [511:0]   spare_q, spare_d;
   logic           spare_full_q, spare_full_d;
   logic           pf_start_q, pf_start_d;
   logic           pf_wait_q, pf_wait_d;
   logic           pf_hit;
`endif

   logic           in_stream;
   logic           hs;
   logic           blk_end;
   logic           waiting;
   logic           drain;
   logic           tmo;
   logic [31:0]    cur_word;

   assign in_stream = (state_q == S_STREAM);
   assign hs        = in_stream & s_axis_tvalid & m_axis_tready;
   // a block is used up by its 16th word or by the end of the message
   assign blk_end   = hs & ((idx_q == 4'd15) | s_axis_tlast);
   assign cur_word  = blk_q[{idx_q, 5'd0} +: 32];

`ifdef CHACHA20_CTRL_PREFETCH_EN
   assign waiting = (state_q == S_WAIT) | pf_wait_q;
   // an outstanding prefetch must land before a new request is issued
   assign drain   = pf_wait_q;
`else
   assign waiting = (state_q == S_WAIT);
   assign drain   = 1'b0;
`endif

   assign tmo = (CORE_TIMEOUT > 0) && waiting && (tmr_q == TMO_LAST);

   always_comb begin
      state_d    = state_q;
      key_d      = key_q;
      nonce_d    = nonce_q;
      ctr_d      = ctr_q;
      blk_d      = blk_q;
      idx_d      = idx_q;
      cfg_seen_d = cfg_seen_q;
      err_d      = err_q;
      tmr_d      = waiting ? tmr_q + 1'b1 : tmr_q;
`ifdef CHACHA20_CTRL_PREFETCH_EN
      spare_d      = spare_q;
      spare_full_d = spare_full_q;
      pf_start_d   = 1'b0;
      pf_wait_d    = pf_wait_q;
      // prefetched block arriving outside WAIT goes to the spare buffer
      // (or is dropped if the message already ended)
      pf_hit = pf_wait_q & ~pf_start_q & i_core_keystream_valid & (state_q != S_WAIT);
      if (pf_hit) begin
         pf_wait_d = 1'b0;
         if (in_stream) begin
            spare_d      = i_core_keystream;
            spare_full_d = 1'b1;
         end
      end
`endif

      case (state_q)
         S_IDLE: begin
            if (i_cfg_valid) begin
               key_d      = i_cfg_key;
               nonce_d    = i_cfg_nonce;
               ctr_d      = i_cfg_counter;
               cfg_seen_d = 1'b1;
               err_d      = 1'b0;
            end else if (s_axis_tvalid & cfg_seen_q & ~err_q & ~drain) begin
               state_d = S_REQ;
            end
         end

         S_REQ: begin
            state_d = S_WAIT;
            tmr_d   = '0;
         end

         S_WAIT: begin
            if (i_core_keystream_valid) begin
               blk_d   = i_core_keystream;
               idx_d   = 4'd0;
               state_d = S_STREAM;
`ifdef CHACHA20_CTRL_PREFETCH_EN
               pf_wait_d = 1'b0;
               if (ctr_q != CTR_MAX) begin
                  pf_start_d = 1'b1;
                  pf_wait_d  = 1'b1;
                  tmr_d      = '0;
               end
`endif
            end else if (tmo) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end

         S_STREAM: begin
            if (hs) begin
               idx_d = idx_q + 1'b1;
            end
            if (blk_end) begin
`ifdef CHACHA20_CTRL_PREFETCH_EN
               // a prefetched counter stays consumed even if its block is dropped
               if (s_axis_tlast) begin
                  ctr_d = ctr_q + ((pf_wait_q | spare_full_q) ? 32'd2 : 32'd1);
               end else begin
                  ctr_d = ctr_q + 32'd1;
               end
               spare_full_d = 1'b0;
`else
               ctr_d = ctr_q + 32'd1;
`endif
               if (s_axis_tlast) begin
                  state_d = S_IDLE;
               end else if (ctr_q == CTR_MAX) begin
                  // counter space exhausted: never reuse counter 0
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
`ifdef CHACHA20_CTRL_PREFETCH_EN
                  if (spare_full_q | pf_hit) begin
                     blk_d = spare_full_q ? spare_q : i_core_keystream;
                     idx_d = 4'd0;
                     if ((ctr_q + 32'd1) != CTR_MAX) begin
                        pf_start_d = 1'b1;
                        pf_wait_d  = 1'b1;
                        tmr_d      = '0;
                     end
                  end else begin
                     // request already outstanding; keep its timer running
                     state_d = S_WAIT;
                  end
`else
                  state_d = S_REQ;
`endif
               end
            end
         end

         default: state_d = S_IDLE;
      endcase

`ifdef CHACHA20_CTRL_PREFETCH_EN
      if (tmo && (state_q != S_WAIT)) begin
         err_d        = 1'b1;
         state_d      = S_IDLE;
         pf_wait_d    = 1'b0;
         spare_full_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         state_q    <= S_IDLE;
         key_q      <= '0;
         nonce_q    <= '0;
         ctr_q      <= '0;
         blk_q      <= '0;
         idx_q      <= '0;
         tmr_q      <= '0;
         cfg_seen_q <= 1'b0;
         err_q      <= 1'b0;
`ifdef CHACHA20_CTRL_PREFETCH_EN
         spare_q      <= '0;
         spare_full_q <= 1'b0;
         pf_start_q   <= 1'b0;
         pf_wait_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         key_q      <= key_d;
         nonce_q    <= nonce_d;
         ctr_q      <= ctr_d;
         blk_q      <= blk_d;
         idx_q      <= idx_d;
         tmr_q      <= tmr_d;
         cfg_seen_q <= cfg_seen_d;
         err_q      <= err_d;
`ifdef CHACHA20_CTRL_PREFETCH_EN
         spare_q      <= spare_d;
         spare_full_q <= spare_full_d;
         pf_start_q   <= pf_start_d;
         pf_wait_q    <= pf_wait_d;
`endif
      end
   end

   // all outputs derive from reset-cleared flops, so reset drops them at once
   assign o_core_enable = (state_q != S_IDLE);
   assign o_busy        = (state_q != S_IDLE);
   assign o_error       = err_q;
   assign o_core_key    = key_q;
   assign o_core_nonce  = nonce_q;
`ifdef CHACHA20_CTRL_PREFETCH_EN
   assign o_core_start   = (state_q == S_REQ) | pf_start_q;
   assign o_core_counter = pf_start_q ? ctr_q + 32'd1 : ctr_q;
`else
   assign o_core_start   = (state_q == S_REQ);
   assign o_core_counter = ctr_q;
`endif

   assign s_axis_tready = in_stream & m_axis_tready;
   assign m_axis_tvalid = in_stream & s_axis_tvalid;
   assign m_axis_tlast  = in_stream & s_axis_tlast;
   assign m_axis_tdata  = in_stream ? (s_axis_tdata ^ cur_word) : 32'd0;

endmodule

// File: tb/tb_chacha20_stream_ctrl.sv
// Testbench for chacha20_stream_ctrl: a behavioural core model returns a
// block 3 cycles after each start pulse; a driver issues plaintext beats and
// pushes the expected ciphertext into a queue, and a monitor pops and
// compares on every output handshake.
module tb_chacha20_stream_ctrl;

   logic           clk = 1'b0;
   logic           i_aresetn;
   logic           i_cfg_valid;
   logic [255:0]   i_cfg_key;
   logic [95:0]    i_cfg_nonce;
   logic [31:0]    i_cfg_counter;
   logic           o_core_enable;
   logic           o_core_start;
   logic [255:0]   o_core_key;
   logic [95:0]    o_core_nonce;
   logic [31:0]    o_core_counter;
   logic [511:0]   core_ks;
   logic           core_valid;
   logic [31:0]    s_axis_tdata;
   logic           s_axis_tvalid;
   logic           s_axis_tlast;
   logic           s_axis_tready;
   logic [31:0]    m_axis_tdata;
   logic           m_axis_tvalid;
   logic           m_axis_tlast;
   logic           m_axis_tready;
   logic           o_busy;
   logic           o_error;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } exp_t;

   exp_t          exp_q[$];
   logic [31:0]   start_log[$];
   int            total = 0;
   int            bad   = 0;
   bit            core_on   = 1'b1;
   bit            rnd_ready = 1'b0;
   logic [255:0]  exp_key;
   logic [95:0]   exp_nonce;
   logic [255:0]  rfc_key;
   logic [95:0]   rfc_nonce;

   chacha20_stream_ctrl #(
      .CORE_TIMEOUT (256),
      .TW           (9)
   ) dut (
      .i_aclk                 (clk),
      .i_aresetn              (i_aresetn),
      .i_cfg_valid            (i_cfg_valid),
      .i_cfg_key              (i_cfg_key),
      .i_cfg_nonce            (i_cfg_nonce),
      .i_cfg_counter          (i_cfg_counter),
      .o_core_enable          (o_core_enable),
      .o_core_start           (o_core_start),
      .o_core_key             (o_core_key),
      .o_core_nonce           (o_core_nonce),
      .o_core_counter         (o_core_counter),
      .i_core_keystream       (core_ks),
      .i_core_keystream_valid (core_valid),
      .s_axis_tdata           (s_axis_tdata),
      .s_axis_tvalid          (s_axis_tvalid),
      .s_axis_tlast           (s_axis_tlast),
      .s_axis_tready          (s_axis_tready),
      .m_axis_tdata           (m_axis_tdata),
      .m_axis_tvalid          (m_axis_tvalid),
      .m_axis_tlast           (m_axis_tlast),
      .m_axis_tready          (m_axis_tready),
      .o_busy                 (o_busy),
      .o_error                (o_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // keystream word k of the block for counter c; counter 1 word 0 is the
   // RFC 8439 2.4.2 value, the rest is an arbitrary distinct pattern
   function automatic logic [31:0] ks_word(input logic [31:0] c, input int k);
      if (c == 32'd1 && k == 0) return 32'hf351_4f22;
      return (c * 32'h9E37_79B9) ^ (32'(k) * 32'h0100_0193) ^ 32'h5A5A_5A5A;
   endfunction

   function automatic logic [511:0] ks_block(input logic [31:0] c);
      logic [511:0] b;
      b = '0;
      for (int k = 0; k < 16; k++) b[32*k +: 32] = ks_word(c, k);
      return b;
   endfunction

   // core model: logs each start and answers after 3 cycles when enabled
   initial begin : core_model
      logic [31:0] c_m;
      core_valid = 1'b0;
      core_ks    = '0;
      forever begin
         @(negedge clk);
         if (i_aresetn && o_core_start) begin
            c_m = o_core_counter;
            start_log.push_back(c_m);
            $display("start counter=%08h", c_m);
            chk("start_enable", 64'(o_core_enable), 64'd1);
            chk("start_key", 64'(o_core_key == exp_key), 64'd1);
            chk("start_nonce", 64'(o_core_nonce == exp_nonce), 64'd1);
            if (core_on) begin
               repeat (3) @(posedge clk);
               #1;
               core_valid = 1'b1;
               core_ks    = ks_block(c_m);
               @(posedge clk);
               #1;
               core_valid = 1'b0;
            end
         end
      end
   end

   // random downstream backpressure
   initial begin : ready_toggler
      forever begin
         @(posedge clk);
         #1;
         if (rnd_ready) m_axis_tready = 1'($urandom_range(0, 1));
      end
   end

   // monitor: every output handshake must match the head of the queue
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (i_aresetn && m_axis_tvalid && m_axis_tready) begin
            $display("beat data=%08h last=%0b", m_axis_tdata, m_axis_tlast);
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", 64'(m_axis_tdata), 64'(e.data));
               chk("beat_last", 64'(m_axis_tlast), 64'(e.last));
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_cfg(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
      i_cfg_valid   = 1'b1;
      i_cfg_key     = k;
      i_cfg_nonce   = n;
      i_cfg_counter = c;
      exp_key       = k;
      exp_nonce     = n;
      @(posedge clk);
      #1;
      i_cfg_valid = 1'b0;
      chk("cfg_counter", 64'(o_core_counter), 64'(c));
      chk("cfg_key", 64'(o_core_key == k), 64'd1);
      chk("cfg_err_clear", 64'(o_error), 64'd0);
   endtask

   // present one beat; ok=0 means the beat must not be accepted
   task automatic drive_beat(input logic [31:0] pt, input logic last, input bit ok);
      bit got;
      int lim;
      got = 1'b0;
      lim = ok ? 600 : 40;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = pt;
      s_axis_tlast  = last;
      for (int w = 0; w < lim && !got; w++) begin
         @(negedge clk);
         if (s_axis_tready) got = 1'b1;
      end
      if (!got) begin
         s_axis_tvalid = 1'b0;
         s_axis_tlast  = 1'b0;
      end
      @(posedge clk);
      #1;
      if (ok) chk("beat_accepted", 64'(got), 64'd1);
      else    chk("beat_blocked", 64'(got), 64'd0);
   endtask

   // n beats from counter c0, first n_ok of them expected to pass
   task automatic send_msg(input int n, input logic [31:0] c0, input int n_ok);
      logic [31:0] pt;
      exp_t        e;
      for (int i = 0; i < n; i++) begin
         pt = 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0107);
         if (i < n_ok) begin
            e.data = pt ^ ks_word(c0 + 32'(i / 16), i % 16);
            e.last = (i == n - 1);
            exp_q.push_back(e);
         end
         drive_beat(pt, (i == n - 1), (i < n_ok));
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   initial begin : main
      bit seen;
      exp_t e;
      i_aresetn     = 1'b0;
      i_cfg_valid   = 1'b0;
      i_cfg_key     = '0;
      i_cfg_nonce   = '0;
      i_cfg_counter = '0;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b1;
      exp_key       = '0;
      exp_nonce     = '0;
      for (int i = 0; i < 32; i++) rfc_key[8*i +: 8] = 8'(i);
      rfc_nonce = 96'h0000_0000_0000_004a_0000_0000;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_error", 64'(o_error), 64'd0);
      chk("rst_start", 64'(o_core_start), 64'd0);
      chk("rst_enable", 64'(o_core_enable), 64'd0);
      chk("rst_counter", 64'(o_core_counter), 64'd0);
      chk("rst_key", 64'(|o_core_key), 64'd0);
      chk("rst_tready", 64'(s_axis_tready), 64'd0);
      chk("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
      i_aresetn = 1'b1;

      // traffic without a cfg must not start the core
      s_axis_tvalid = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("nocfg_busy", 64'(o_busy), 64'd0);
      chk("nocfg_starts", 64'(start_log.size()), 64'd0);
      s_axis_tvalid = 1'b0;

      // RFC 8439 2.4.2 first beat
      do_cfg(rfc_key, rfc_nonce, 32'd1);
      start_log.delete();
      e.data = 32'h9a35_2e6e;
      e.last = 1'b1;
      exp_q.push_back(e);
      drive_beat(32'h6964_614c, 1'b1, 1'b1);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      chk("rfc_nstarts", 64'(start_log.size()), 64'd1);
      if (start_log.size() > 0) chk("rfc_start_ctr", 64'(start_log[0]), 64'd1);
      chk("rfc_ctr_after", 64'(o_core_counter), 64'd2);
      chk("rfc_idle", 64'(o_busy), 64'd0);

      // 40-beat message spans counters 1,2,3
      do_cfg(rfc_key, rfc_nonce, 32'd1);
      start_log.delete();
      send_msg(40, 32'd1, 40);
      chk("m40_nstarts", 64'(start_log.size()), 64'd3);
      for (int i = 0; i < 3 && i < start_log.size(); i++)
         chk("m40_start_ctr", 64'(start_log[i]), 64'(i + 1));
      chk("m40_ctr_after", 64'(o_core_counter), 64'd4);
      chk("m40_idle", 64'(o_busy), 64'd0);
      chk("m40_queue_empty", 64'(exp_q.size()), 64'd0);

      // 16-beat block under random backpressure
      do_cfg(rfc_key ^ {8{32'h1234_5678}}, rfc_nonce, 32'd10);
      start_log.delete();
      rnd_ready = 1'b1;
      send_msg(16, 32'd10, 16);
      rnd_ready     = 1'b0;
      m_axis_tready = 1'b1;
      chk("rnd_nstarts", 64'(start_log.size()), 64'd1);
      if (start_log.size() > 0) chk("rnd_start_ctr", 64'(start_log[0]), 64'd10);
      chk("rnd_ctr_after", 64'(o_core_counter), 64'd11);
      chk("rnd_queue_empty", 64'(exp_q.size()), 64'd0);

      // counter exhaustion: 16 beats pass, beat 17 blocked with error
      do_cfg(rfc_key, rfc_nonce, 32'hFFFF_FFFF);
      start_log.delete();
      send_msg(17, 32'hFFFF_FFFF, 16);
      s_axis_tvalid = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("wrap_error", 64'(o_error), 64'd1);
      chk("wrap_tready", 64'(s_axis_tready), 64'd0);
      chk("wrap_nstarts", 64'(start_log.size()), 64'd1);
      if (start_log.size() > 0) chk("wrap_start_ctr", 64'(start_log[0]), 64'hFFFF_FFFF);
      chk("wrap_queue_empty", 64'(exp_q.size()), 64'd0);
      s_axis_tvalid = 1'b0;

      // core timeout
      do_cfg(rfc_key, rfc_nonce, 32'd5);
      core_on = 1'b0;
      start_log.delete();
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'h5555_aaaa;
      seen = 1'b0;
      for (int w = 0; w < 20 && !seen; w++) begin
         @(negedge clk);
         if (o_core_start) seen = 1'b1;
      end
      chk("tmo_start_seen", 64'(seen), 64'd1);
      for (int k = 1; k <= 258; k++) begin
         @(negedge clk);
         if (k == 255) chk("tmo_not_early", 64'(o_error), 64'd0);
         if (k == 258) chk("tmo_error", 64'(o_error), 64'd1);
      end
      chk("tmo_tready", 64'(s_axis_tready), 64'd0);
      chk("tmo_idle", 64'(o_busy), 64'd0);
      s_axis_tvalid = 1'b0;
      @(posedge clk);
      #1;
      core_on = 1'b1;
      do_cfg(rfc_key, rfc_nonce, 32'd5);
      chk("tmo_nstarts", 64'(start_log.size()), 64'd1);

      // reset during STREAM at beat 5
      do_cfg(rfc_key, rfc_nonce, 32'd20);
      send_msg(4, 32'd20, 4);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'hDEAD_BEEF;
      #2;
      i_aresetn = 1'b0;
      #1;
      chk("arst_mvalid", 64'(m_axis_tvalid), 64'd0);
      chk("arst_tready", 64'(s_axis_tready), 64'd0);
      chk("arst_mdata", 64'(m_axis_tdata), 64'd0);
      chk("arst_busy", 64'(o_busy), 64'd0);
      chk("arst_enable", 64'(o_core_enable), 64'd0);
      chk("arst_counter", 64'(o_core_counter), 64'd0);
      chk("arst_key", 64'(|o_core_key), 64'd0);
      @(posedge clk);
      #1;
      i_aresetn = 1'b1;
      start_log.delete();
      repeat (20) @(posedge clk);
      #1;
      chk("arst_no_start", 64'(start_log.size()), 64'd0);
      chk("arst_still_idle", 64'(o_busy), 64'd0);
      s_axis_tvalid = 1'b0;
      do_cfg(rfc_key, rfc_nonce, 32'd7);
      send_msg(1, 32'd7, 1);
      chk("arst_nstarts", 64'(start_log.size()), 64'd1);
      if (start_log.size() > 0) chk("arst_start_ctr", 64'(start_log[0]), 64'd7);
      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/chacha20_stream_ctrl.md
Name: chacha20_stream_ctrl

Overview:
Sequencer that drives the chacha20 keystream core and turns its 512-bit blocks into a 32-bit AXI-Stream cipher path.
- Latches key, nonce and initial block counter.
- Requests one block at a time from the core, advancing the counter per block.
- Buffers each block and XORs its 16 words, in order, onto plaintext beats.
- Sits between the DMA/stream fabric and the chacha20 core instance.

Parameters:
CORE_TIMEOUT, 256, max cycles to wait for o_keystream_valid after start before error; 0 disables the timeout
TW, 9, width of the timeout counter; must satisfy 2^TW > CORE_TIMEOUT

Ports:
i_aclk  in  1  clock
i_aresetn  in  1  asynchronous active-low reset
i_cfg_valid  in  1  one-cycle pulse that latches i_cfg_key, i_cfg_nonce, i_cfg_counter
i_cfg_key  in  256  key
i_cfg_nonce  in  96  nonce
i_cfg_counter  in  32  initial block counter
o_core_enable  out  1  core i_enable
o_core_start  out  1  core i_start, one-cycle pulse
o_core_key  out  256  latched key
o_core_nonce  out  96  latched nonce
o_core_counter  out  32  current block counter
i_core_keystream  in  512  core o_keystream
i_core_keystream_valid  in  1  core o_keystream_valid
s_axis_tdata  in  32  plaintext
s_axis_tvalid  in  1  plaintext valid
s_axis_tlast  in  1  end of message
s_axis_tready  out  1  plaintext ready
m_axis_tdata  out  32  ciphertext
m_axis_tvalid  out  1  ciphertext valid
m_axis_tlast  out  1  end of message
m_axis_tready  in  1  downstream ready
o_busy  out  1  high whenever the FSM is not in IDLE
o_error  out  1  sticky error flag

Behaviour:
- Reset values: all outputs 0, latched key/nonce/counter 0, FSM in IDLE, word index 0.
- Reset mid-operation aborts immediately; no beat is emitted afterwards.
- FSM states:
  - IDLE: waits for s_axis_tvalid with the config latched (a cfg pulse seen since reset) and o_error=0, then goes to REQ.
  - REQ: o_core_start=1 for exactly one cycle; next state WAIT.
  - WAIT: clears the timeout counter on entry. On i_core_keystream_valid, captures the 512-bit block into the buffer, sets word index 0 and goes to STREAM. If the timer reaches CORE_TIMEOUT, sets o_error and goes to IDLE.
  - STREAM: serves buffer words (see Datapath).
- Datapath (STREAM only):
  - Word k = buffer[32k+31:32k], so word 0 is the low 32 bits (RFC 8439 little-endian order).
  - m_axis_tdata = s_axis_tdata XOR word[idx], combinational, zero latency.
  - m_axis_tvalid = s_axis_tvalid; s_axis_tready = m_axis_tready; m_axis_tlast = s_axis_tlast. All three are forced to 0 outside STREAM.
  - A handshake is s_axis_tvalid & m_axis_tready in STREAM; each handshake increments idx.
- Block end and counter wrap:
  - A handshake on idx=15, or a handshake with tlast, consumes the block. o_core_counter increments by 1, modulo 2^32.
  - Unused words after tlast are discarded. The next message starts with a fresh block at the incremented counter.
  - After a block is consumed: tlast goes to IDLE; otherwise go to REQ.
  - If the block just consumed used counter 32'hFFFFFFFF and tlast was not set: set o_error, go to IDLE, and do not wrap-reuse a counter.
- o_core_enable = 1 in REQ, WAIT and STREAM.
- i_cfg_valid:
  - Accepted in IDLE only; ignored in any other state.
  - Clears o_error and reloads key, nonce and counter.
- o_error is cleared only by reset or by an accepted cfg.

Optional Feature:
Macro CHACHA20_CTRL_PREFETCH_EN.
- Defined:
  - Adds a second 512-bit buffer.
  - On entering STREAM, the controller issues start for counter+1 (when counter != 32'hFFFFFFFF) and captures that block into the spare buffer.
  - At block end it swaps buffers with no bubble when the spare is full; otherwise it waits in WAIT.
  - On tlast the prefetched block is discarded, but its counter stays consumed.
  - The timeout applies to the prefetch request too.
- Undefined: single buffer; each block goes through REQ/WAIT with at least 2 bubble cycles.

Test Plan:
- RFC 8439 2.4.2: key 00..1f, nonce 000000000000004a00000000, counter 1; plaintext beat 32'h6964614c -> m_axis_tdata 32'h9a352e6e, o_core_counter=1 at the first start.
- 40-beat message with tlast on beat 40 -> 3 start pulses with counters 1, 2, 3; tlast is output on beat 40; o_core_counter=4 at the end; FSM returns to IDLE.
- m_axis_tready toggled randomly during a 16-beat block -> no word skipped or repeated; idx advances only on handshake; output matches the reference XOR.
- Core model never asserts valid with CORE_TIMEOUT=256 -> o_error=1 at 256 cycles after start; s_axis_tready=0; a new cfg pulse clears o_error.
- Counter 32'hFFFFFFFF with a 17-beat message -> 16 beats pass, then o_error=1 and tready=0 from beat 17, with no start pulse for counter 0.
- Reset asserted during STREAM at beat 5 -> all outputs 0 asynchronously; after release, the cfg pulse is required again before any new start pulse.
